// File: rtl/mio_pkg.sv
// Shared types and constants for the MIO bus arbiter.
// Holds the FSM state encoding, the RAM region tag and the master indices.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] RAM_REGION = 4'h0;
    localparam logic       M_CPU      = 1'b0;
    localparam logic       M_DBG      = 1'b1;

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Two-requester round-robin pick; a tie goes to the master that did not win last.
// Purely combinational: zero latency, no backpressure of its own.
module rr_arb2
    import mio_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       vld_o,
    output logic       winner_o
);

    always_comb begin
        vld_o    = |req_i;
        winner_o = M_CPU;
        if (req_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else if (req_i[1]) begin
            winner_o = M_DBG;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter and access sequencer for the MIO bus slave port.
// Latency: ready 2+wait cycles after the request is sampled; requests wait in IDLE until the bus is free.
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              grant,
    output logic              busy
);

    localparam int WAIT_MAX = (RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT;
    localparam int WCW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    state_e            state_q;
    logic [WCW-1:0]    wait_q;
    logic              we_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              busy_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] s_wdata_q;
    logic              s_we_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              m0_ready_q;
    logic              m1_ready_q;

    logic              pick_vld_d;
    logic              pick_idx_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;
    logic              sel_we_d;
    logic [WCW-1:0]    wait_load_d;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req, m0_req}),
        .last_grant_i (last_grant_q),
        .vld_o        (pick_vld_d),
        .winner_o     (pick_idx_d)
    );

    always_comb begin
        sel_addr_d  = (pick_idx_d == M_DBG) ? m1_addr  : m0_addr;
        sel_wdata_d = (pick_idx_d == M_DBG) ? m1_wdata : m0_wdata;
        sel_we_d    = (pick_idx_d == M_DBG) ? m1_we    : m0_we;
        // RAM sits on the inverted clock and needs its own wait budget
        wait_load_d = (sel_addr_d[ADDR_W-1 -: 4] == RAM_REGION) ? WCW'(RAM_WAIT) : WCW'(IO_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_we_q       <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
        end else begin
            s_we_q     <= 1'b0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        s_addr_q     <= sel_addr_d;
                        s_wdata_q    <= sel_wdata_d;
                        s_we_q       <= sel_we_d;
                        we_q         <= sel_we_d;
                        grant_q      <= pick_idx_d;
                        last_grant_q <= pick_idx_d;
                        wait_q       <= wait_load_d;
                        busy_q       <= 1'b1;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WCW'(1);
                    end else begin
                        if (!we_q) begin
                            if (grant_q == M_DBG) m1_rdata_q <= s_rdata;
                            else                  m0_rdata_q <= s_rdata;
                        end
                        if (grant_q == M_DBG) m1_ready_q <= 1'b1;
                        else                  m0_ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_we     = s_we_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (round-robin pick, region wait, rdata shadow).
module tb_mio_bus_arbiter;

    localparam int RAM_WAIT = 1;
    localparam int IO_WAIT  = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_we, grant, busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rd [2];
    logic        last_g;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata),
        .grant(grant), .busy(busy)
    );

    function automatic int exp_wait(input logic [31:0] a);
        return (a[31:28] == 4'h0) ? RAM_WAIT : IO_WAIT;
    endfunction

    function automatic logic ready_of(input logic m);
        return m ? m1_ready : m0_ready;
    endfunction

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (m) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; end
        else   begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        last_g    = 1'b1;
    endtask

    // Single-master transaction driver; scrambles the owner's inputs once granted.
    task automatic run_txn(input logic m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int swe_n, output logic [31:0] swe_a,
                           output logic [31:0] swe_d, output logic g, output bit moved);
        drive(m, 1'b1, we, a, wd);
        lat = 0; swe_n = 0; swe_a = 'x; swe_d = 'x; g = 1'bx; moved = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (s_we) begin swe_n++; swe_a = s_addr; swe_d = s_wdata; end
            if (busy && s_addr !== a) moved = 1;
            if (ready_of(m)) begin g = grant; break; end
            if (busy) drive(m, 1'b1, ~we, $urandom, $urandom);
        end
        if (lat >= 30) lat = 99;
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        s_rdata = 32'h0;
        #7;
        tests++;
        if ({m0_rdata, m1_rdata, m0_ready, m1_ready, s_addr, s_wdata, s_we, grant, busy} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs busy=%b grant=%b s_addr=%h", busy, grant, s_addr);
        end
        apply_reset();
        tests++;
        if (busy !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b m0_ready=%b m1_ready=%b required 0", busy, m0_ready, m1_ready);
        end
    endtask

    task automatic test_cpu_read();
        int lat, swe_n; logic [31:0] sa, sd; logic g; bit moved;
        s_rdata = 32'hDEADBEEF;
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, swe_n, sa, sd, g, moved);
        exp_rd[0] = 32'hDEADBEEF;
        tests++; if (lat !== 2 + exp_wait(32'h10)) begin fails++; $display("FAIL cpu_read_latency: got %0d required %0d", lat, 2 + exp_wait(32'h10)); end
        tests++; if (swe_n !== 0) begin fails++; $display("FAIL cpu_read_swe: s_we high %0d cycles required 0", swe_n); end
        tests++; if (m0_rdata !== exp_rd[0]) begin fails++; $display("FAIL cpu_read_rdata: got %h required %h", m0_rdata, exp_rd[0]); end
        tests++; if (m1_rdata !== exp_rd[1]) begin fails++; $display("FAIL cpu_read_m1_rdata: got %h required %h", m1_rdata, exp_rd[1]); end
        tests++; if (g !== 1'b0 || moved) begin fails++; $display("FAIL cpu_read_grant: grant %b moved %0d required 0/0", g, moved); end
    endtask

    task automatic test_dbg_write();
        int lat, swe_n; logic [31:0] sa, sd; logic g; bit moved;
        s_rdata = 32'h1234_5678;
        run_txn(1'b1, 1'b1, 32'hF000_0000, 32'h0000_00A5, lat, swe_n, sa, sd, g, moved);
        tests++; if (lat !== 2 + exp_wait(32'hF000_0000)) begin fails++; $display("FAIL dbg_write_latency: got %0d required %0d", lat, 2 + exp_wait(32'hF000_0000)); end
        tests++; if (swe_n !== 1) begin fails++; $display("FAIL dbg_write_swe_cycles: got %0d required 1", swe_n); end
        tests++; if (sa !== 32'hF000_0000 || sd !== 32'h0000_00A5) begin fails++; $display("FAIL dbg_write_bus: addr %h data %h required f0000000/000000a5", sa, sd); end
        tests++; if (m1_rdata !== exp_rd[1] || m0_rdata !== exp_rd[0]) begin fails++; $display("FAIL dbg_write_rdata: m0 %h m1 %h required %h %h", m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]); end
        tests++; if (g !== 1'b1 || moved) begin fails++; $display("FAIL dbg_write_grant: grant %b moved %0d required 1/0", g, moved); end
        last_g = 1'b1;
    endtask

    task automatic test_tie_alternate();
        int ev = 0;
        logic w_exp;
        apply_reset();
        s_rdata = 32'h1111_2222;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        for (int c = 0; c < 60 && ev < 4; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                w_exp = ~last_g;
                tests++;
                if (m1_ready !== w_exp || m0_ready !== ~w_exp || grant !== w_exp) begin
                    fails++; $display("FAIL tie_order_%0d: m0_ready %b m1_ready %b grant %b required grant %b", ev, m0_ready, m1_ready, grant, w_exp);
                end
                tests++;
                if ((w_exp ? m1_rdata : m0_rdata) !== 32'h1111_2222) begin
                    fails++; $display("FAIL tie_rdata_%0d: got %h required 11112222", ev, w_exp ? m1_rdata : m0_rdata);
                end
                last_g = w_exp;
                ev++;
            end
        end
        tests++; if (ev !== 4) begin fails++; $display("FAIL tie_count: got %0d transactions required 4", ev); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        exp_rd[0] = 32'h1111_2222;
        exp_rd[1] = 32'h1111_2222;
    endtask

    task automatic test_drop_req();
        int pulses = 0, other = 0;
        s_rdata = 32'hA1B2_C3D4;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL drop_busy: got %b required 1", busy); end
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m0_ready) pulses++;
            if (m1_ready) other++;
        end
        exp_rd[0] = 32'hA1B2_C3D4;
        last_g = 1'b0;
        tests++; if (pulses !== 1 || other !== 0) begin fails++; $display("FAIL drop_ready: m0 pulses %0d m1 pulses %0d required 1/0", pulses, other); end
        tests++; if (m0_rdata !== exp_rd[0] || busy !== 1'b0) begin fails++; $display("FAIL drop_rdata: got %h busy %b required %h busy 0", m0_rdata, busy, exp_rd[0]); end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0055);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({m0_rdata, m1_rdata, m0_ready, m1_ready, s_addr, s_wdata, s_we, grant, busy} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs: busy %b s_we %b s_addr %h m0_rdata %h required all 0", busy, s_we, s_addr, m0_rdata);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; last_g = 1'b1;
        s_rdata = 32'h0BAD_F00D;
        drive(1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h3000_0004, 32'h0);
        while (lat < 30 && !(m0_ready || m1_ready)) begin @(negedge clk); lat++; end
        tests++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || grant !== 1'b0) begin
            fails++; $display("FAIL reset_mid_first_grant: m0_ready %b m1_ready %b grant %b required CPU", m0_ready, m1_ready, grant);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        exp_rd[0] = 32'h0BAD_F00D;
        last_g = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc = 0, n = 0, prev = 0;
        logic [31:0] a = 32'h2000_0100;
        s_rdata = 32'h0000_0100;
        drive(1'b0, 1'b1, 1'b0, a, 32'h0);
        while (cyc < 40 && n < 3) begin
            @(negedge clk);
            cyc++;
            if (m0_ready) begin
                tests++;
                if (cyc - prev !== ((n == 0) ? 2 + exp_wait(a) : 3 + exp_wait(a))) begin
                    fails++; $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d", n, cyc - prev, (n == 0) ? 2 + exp_wait(a) : 3 + exp_wait(a));
                end
                tests++;
                if (m0_rdata !== s_rdata) begin fails++; $display("FAIL b2b_rdata_%0d: got %h required %h", n, m0_rdata, s_rdata); end
                exp_rd[0] = s_rdata;
                s_rdata = s_rdata + 32'h1;
                prev = cyc;
                n++;
                if (n == 3) drive(1'b0, 1'b0, 1'b0, a, 32'h0);
            end
        end
        tests++; if (n !== 3) begin fails++; $display("FAIL b2b_count: got %0d pulses required 3", n); end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        last_g = 1'b0;
    endtask

    task automatic test_random();
        logic        we [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [1:0]  mask;
        logic        w;
        logic [31:0] rd, swe_a, swe_d;
        logic [3:0]  rgn;
        int          lat, swe_n;
        bit          moved;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                we[m] = 1'($urandom_range(0, 1));
                rgn   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                a[m]  = {rgn, 28'($urandom)};
                wd[m] = $urandom;
            end
            w  = (mask == 2'b11) ? ~last_g : mask[1];
            rd = $urandom;
            s_rdata = rd;
            drive(1'b0, mask[0], we[0], a[0], wd[0]);
            drive(1'b1, mask[1], we[1], a[1], wd[1]);
            lat = 0; swe_n = 0; moved = 0; swe_a = 'x; swe_d = 'x;
            while (lat < 30) begin
                @(negedge clk);
                lat++;
                if (s_we) begin swe_n++; swe_a = s_addr; swe_d = s_wdata; end
                if (busy && s_addr !== a[w]) moved = 1;
                if (m0_ready || m1_ready) break;
                if (busy) drive(w, 1'b1, ~we[w], $urandom, $urandom);
            end
            if (!we[w]) exp_rd[w] = rd;
            tests++;
            if (ready_of(w) !== 1'b1 || ready_of(~w) !== 1'b0 || grant !== w) begin
                fails++; $display("FAIL rand_%0d_winner: m0_ready %b m1_ready %b grant %b required winner %b", it, m0_ready, m1_ready, grant, w);
            end
            tests++;
            if (lat !== 2 + exp_wait(a[w])) begin fails++; $display("FAIL rand_%0d_latency: got %0d required %0d", it, lat, 2 + exp_wait(a[w])); end
            tests++;
            if (swe_n !== int'(we[w]) || (we[w] && (swe_a !== a[w] || swe_d !== wd[w]))) begin
                fails++; $display("FAIL rand_%0d_strobe: cycles %0d addr %h data %h required %0d %h %h", it, swe_n, swe_a, swe_d, we[w], a[w], wd[w]);
            end
            tests++;
            if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1] || moved) begin
                fails++; $display("FAIL rand_%0d_rdata: m0 %h m1 %h moved %0d required %h %h 0", it, m0_rdata, m1_rdata, moved, exp_rd[0], exp_rd[1]);
            end
            last_g = w;
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || s_we !== 1'b0) begin fails++; $display("FAIL rand_%0d_idle: busy %b s_we %b required 0 0", it, busy, s_we); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_tie_alternate();
        test_drop_req();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the MIO bus slave port (RAM, GPIO, counter).
- Master 0 is the multi-cycle CPU; master 1 is a debug/program-loader port.
- Grants one master at a time, drives the shared address/data/write strobe, inserts region-dependent wait states and returns a one-cycle ready pulse plus read data.
- Replaces the button-driven MIO_ready with a real handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RAM_WAIT, 1, extra wait cycles for accesses with addr[31:28]==4'h0 (RAM runs on the inverted clock).
- IO_WAIT, 0, extra wait cycles for all other regions.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU request, held until m0_ready.
- m0_we  in  1  CPU write (1) / read (0).
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_rdata  out  DATA_W  CPU read data, registered.
- m0_ready  out  1  CPU completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready  same as m0_*, for the debug port.
- s_addr  out  ADDR_W  bus address.
- s_wdata  out  DATA_W  bus write data.
- s_we  out  1  bus write strobe.
- s_rdata  in  DATA_W  bus read data.
- grant  out  1  owner of the current or last transaction (0 = CPU, 1 = debug).
- busy  out  1  high while not IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - All outputs 0: m*_ready, m*_rdata, s_addr, s_wdata, s_we, grant, busy.
  - last_grant = 1, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner by round-robin (one requester wins; two requesters -> the one not equal to last_grant).
  - On that edge, register the winner's addr/wdata/we into s_*, set grant and last_grant, load wait_cnt, go to ACCESS.
  - wait_cnt load value: RAM_WAIT if addr[31:28]==0, else IO_WAIT.
- ACCESS:
  - busy = 1.
  - s_we = 1 only in the first ACCESS cycle of a write, exactly one cycle.
  - s_addr/s_wdata held stable for the whole transaction.
  - wait_cnt != 0: decrement.
  - wait_cnt == 0: capture s_rdata into the granted master's rdata (reads only), go to DONE.
- DONE:
  - Granted master's ready = 1 for exactly one cycle; go to IDLE.
  - The other master's rdata is unchanged.
- Latency: request high in IDLE at edge N -> ready high in cycle N+2+wait (RAM default: N+3). Minimum transaction is 3 cycles including IDLE.
- Master rule: req is deasserted on the edge that samples ready. A req still high in IDLE starts a new transaction. Back-to-back throughput is one transaction per 3+wait cycles.
- Request dropped mid-transaction: no abort; the transaction completes and ready still pulses.
- Request inputs of the non-granted master are ignored until IDLE. Changes to the granted master's addr/wdata/we after grant are ignored.
- Writes leave rdata unchanged.
- s_addr/s_wdata keep their last values in IDLE; only s_we returns to 0.
- Reset mid-transaction: immediate abort and all outputs cleared. A write strobe already issued is not retracted.

Decomposition:
- Shared package mio_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - region constant RAM_REGION = 4'h0;
  - master index constants M_CPU = 0, M_DBG = 1.
- One natural sub-module: rr_arb2, a combinational two-requester round-robin pick from req[1:0] and last_grant. The wait counter and FSM stay in the top module.

Test Plan:
- CPU read from 0x00000010, s_rdata = 0xDEADBEEF, RAM_WAIT = 1 -> s_we never high; m0_ready pulses 3 cycles after req is sampled; m0_rdata = 0xDEADBEEF; m1_rdata still 0.
- Debug write 0xF0000000 <- 0x000000A5, IO_WAIT = 0 -> s_we high exactly one cycle with s_addr = 0xF0000000 and s_wdata = 0xA5; m1_ready 2 cycles after the sample.
- Both masters request in the same IDLE cycle after reset -> CPU served first (grant = 0), then debug (grant = 1). Both request again -> debug is not starved; grants alternate 0,1,0,1 over 4 transactions.
- CPU drops m0_req during ACCESS of a RAM read -> transaction completes, m0_ready still pulses once, FSM returns to IDLE.
- rst_n low during ACCESS of a debug write -> all outputs 0 immediately and busy = 0. After release, a CPU request is granted first (last_grant = 1).
- CPU holds req high through ready for 3 back-to-back reads -> three ready pulses, each 3 cycles apart; rdata updates at each pulse.
